// File: rtl/alu_issue_stage_if.sv
// Decode-to-ALU bundle for the issue stage: upstream op/operand inputs, downstream handshake
// and decoded ALU operands. The slave modport is the issue stage's view.
`timescale 1ns/1ps
interface alu_issue_stage_if #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned ALUCONTROL_WIDTH = 4
);
  logic                        valid_i;
  logic                        ready_o;
  logic [2:0]                  alu_op_i;
  logic [5:0]                  funct_i;
  logic [4:0]                  shamt_i;
  logic                        alu_src_i;
  logic [WIDTH-1:0]            rs_data_i;
  logic [WIDTH-1:0]            rt_data_i;
  logic [WIDTH-1:0]            imm_i;
  logic                        valid_o;
  logic                        ready_i;
  logic [WIDTH-1:0]            src1_o;
  logic [WIDTH-1:0]            src2_o;
  logic [ALUCONTROL_WIDTH-1:0] alu_control_o;
  logic                        illegal_o;

  modport slave (
    input  valid_i, alu_op_i, funct_i, shamt_i, alu_src_i, rs_data_i, rt_data_i, imm_i,
    input  ready_i,
    output ready_o, valid_o, src1_o, src2_o, alu_control_o, illegal_o
  );

  modport master (
    output valid_i, alu_op_i, funct_i, shamt_i, alu_src_i, rs_data_i, rt_data_i, imm_i,
    output ready_i,
    input  ready_o, valid_o, src1_o, src2_o, alu_control_o, illegal_o
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes ALUOp/funct into an ALU control code, selects operands and
// holds up to two decoded ops in a circular buffer presented to the ALU via valid/ready.
`timescale 1ns/1ps
module alu_issue_stage #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned ALUCONTROL_WIDTH = 4,
  parameter int unsigned DEPTH            = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  alu_issue_stage_if.slave bus
);

  localparam logic [ALUCONTROL_WIDTH-1:0] CtlAnd  = ALUCONTROL_WIDTH'(4'b0000);
  localparam logic [ALUCONTROL_WIDTH-1:0] CtlOr   = ALUCONTROL_WIDTH'(4'b0001);
  localparam logic [ALUCONTROL_WIDTH-1:0] CtlAdd  = ALUCONTROL_WIDTH'(4'b0010);
  localparam logic [ALUCONTROL_WIDTH-1:0] CtlSub  = ALUCONTROL_WIDTH'(4'b0110);
  localparam logic [ALUCONTROL_WIDTH-1:0] CtlSlt  = ALUCONTROL_WIDTH'(4'b0111);
  localparam logic [ALUCONTROL_WIDTH-1:0] CtlSll  = ALUCONTROL_WIDTH'(4'b1000);
  localparam logic [ALUCONTROL_WIDTH-1:0] CtlIll  = ALUCONTROL_WIDTH'(4'b1111);

  // Decode of the incoming op
  logic [ALUCONTROL_WIDTH-1:0] dec_ctrl;
  logic                        dec_illegal;
  logic                        dec_sll;
  logic [WIDTH-1:0]            dec_src1;
  logic [WIDTH-1:0]            dec_src2;

  always_comb begin
    dec_ctrl    = CtlIll;
    dec_illegal = 1'b1;
    dec_sll     = 1'b0;
    case (bus.alu_op_i)
      3'b000: begin dec_ctrl = CtlAdd; dec_illegal = 1'b0; end
      3'b001: begin dec_ctrl = CtlSub; dec_illegal = 1'b0; end
      3'b010: begin
        dec_illegal = 1'b0;
        case (bus.funct_i)
          6'b100000: dec_ctrl = CtlAdd;
          6'b100010: dec_ctrl = CtlSub;
          6'b100100: dec_ctrl = CtlAnd;
          6'b100101: dec_ctrl = CtlOr;
          6'b101010: dec_ctrl = CtlSlt;
          6'b000000: begin dec_ctrl = CtlSll; dec_sll = 1'b1; end
          default:   begin dec_ctrl = CtlIll; dec_illegal = 1'b1; end
        endcase
      end
      3'b011: begin dec_ctrl = CtlSlt; dec_illegal = 1'b0; end
      3'b100: begin dec_ctrl = CtlOr;  dec_illegal = 1'b0; end
      3'b101: begin dec_ctrl = CtlAnd; dec_illegal = 1'b0; end
      default: begin dec_ctrl = CtlIll; dec_illegal = 1'b1; end
    endcase
  end

  assign dec_src1 = dec_sll ? WIDTH'(bus.shamt_i) : bus.rs_data_i;
  assign dec_src2 = bus.alu_src_i ? bus.imm_i : bus.rt_data_i;

  // Buffer state
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;

  logic [WIDTH-1:0]            src1_q [DEPTH];
  logic [WIDTH-1:0]            src2_q [DEPTH];
  logic [ALUCONTROL_WIDTH-1:0] ctrl_q [DEPTH];
  logic                        ill_q  [DEPTH];

  logic ready;
  logic valid;
  logic accept;
  logic issue;

  // ready depends only on registered occupancy, never on ready_i
  assign ready  = (count_q < 2'd2);
  assign valid  = (count_q != 2'd0);
  assign accept = bus.valid_i & ready;
  assign issue  = valid & bus.ready_i;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (accept) wr_ptr_d = ~wr_ptr_q;
      if (issue)  rd_ptr_d = ~rd_ptr_q;
      case ({accept, issue})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entries are cleared on reset so the head reads as zero until the first accept
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        src1_q[i] <= '0;
        src2_q[i] <= '0;
        ctrl_q[i] <= '0;
        ill_q[i]  <= 1'b0;
      end
    end else if (accept && !flush_i) begin
      src1_q[wr_ptr_q] <= dec_src1;
      src2_q[wr_ptr_q] <= dec_src2;
      ctrl_q[wr_ptr_q] <= dec_ctrl;
      ill_q[wr_ptr_q]  <= dec_illegal;
    end
  end

  assign bus.ready_o       = ready;
  assign bus.valid_o       = valid;
  assign bus.src1_o        = src1_q[rd_ptr_q];
  assign bus.src2_o        = src2_q[rd_ptr_q];
  assign bus.alu_control_o = ctrl_q[rd_ptr_q];
  assign bus.illegal_o     = ill_q[rd_ptr_q];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed scenarios followed by random traffic,
// checked against a queue-based reference model of the two-entry issue buffer.
`timescale 1ns/1ps
module tb_alu_issue_stage;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [3:0]   ctl;
    logic         ill;
  } exp_t;

  typedef struct {
    logic         v;
    logic [2:0]   op;
    logic [5:0]   fn;
    logic [4:0]   sh;
    logic         src;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] imm;
  } stim_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  alu_issue_stage_if #(.WIDTH(W), .ALUCONTROL_WIDTH(4)) bus ();

  alu_issue_stage #(.WIDTH(W), .ALUCONTROL_WIDTH(4), .DEPTH(2)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  int   occ_pre = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference decode straight from the opcode table
  function automatic exp_t ref_decode(input stim_t s);
    exp_t e;
    bit   is_sll = 1'b0;
    logic [3:0] c = 4'hF;
    if      (s.op == 3'd0) c = 4'h2;
    else if (s.op == 3'd1) c = 4'h6;
    else if (s.op == 3'd3) c = 4'h7;
    else if (s.op == 3'd4) c = 4'h1;
    else if (s.op == 3'd5) c = 4'h0;
    else if (s.op == 3'd2) begin
      if      (s.fn == 6'h20) c = 4'h2;
      else if (s.fn == 6'h22) c = 4'h6;
      else if (s.fn == 6'h24) c = 4'h0;
      else if (s.fn == 6'h25) c = 4'h1;
      else if (s.fn == 6'h2A) c = 4'h7;
      else if (s.fn == 6'h00) begin c = 4'h8; is_sll = 1'b1; end
    end
    e.ctl = c;
    e.ill = (c == 4'hF);
    e.s1  = is_sll ? {{(W-5){1'b0}}, s.sh} : s.rs;
    e.s2  = s.src ? s.imm : s.rt;
    return e;
  endfunction

  function automatic stim_t mk(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                               input logic src, input logic [W-1:0] rs, input logic [W-1:0] rt,
                               input logic [W-1:0] imm);
    stim_t s;
    s.v = 1'b1; s.op = op; s.fn = fn; s.sh = sh; s.src = src; s.rs = rs; s.rt = rt; s.imm = imm;
    return s;
  endfunction

  function automatic stim_t idle();
    stim_t s = mk(3'd0, 6'd0, 5'd0, 1'b0, '0, '0, '0);
    s.v = 1'b0;
    return s;
  endfunction

  // Monitor: every cycle compare handshake state and head entry against the model
  always @(negedge clk) begin
    if (rst_n) begin
      occ_pre = exp_q.size();
      check("valid_o", W'(bus.valid_o), W'(occ_pre != 0));
      check("ready_o", W'(bus.ready_o), W'(occ_pre < 2));
      if (occ_pre != 0 && bus.valid_o) begin
        check("src1_o",        bus.src1_o,            exp_q[0].s1);
        check("src2_o",        bus.src2_o,            exp_q[0].s2);
        check("alu_control_o", W'(bus.alu_control_o), W'(exp_q[0].ctl));
        check("illegal_o",     W'(bus.illegal_o),     W'(exp_q[0].ill));
      end
      if (flush) exp_q.delete();
      else if (occ_pre != 0 && bus.ready_i) void'(exp_q.pop_front());
    end
  end

  // Driver: apply one cycle of stimulus; push the expected op if the model says it was accepted
  task automatic cycle(input stim_t s, input logic rdy, input logic fl, output logic acc);
    @(posedge clk);
    #1;
    bus.valid_i   = s.v;
    bus.alu_op_i  = s.op;
    bus.funct_i   = s.fn;
    bus.shamt_i   = s.sh;
    bus.alu_src_i = s.src;
    bus.rs_data_i = s.rs;
    bus.rt_data_i = s.rt;
    bus.imm_i     = s.imm;
    bus.ready_i   = rdy;
    flush         = fl;
    @(negedge clk);
    #1;
    acc = s.v && !fl && (occ_pre < 2);
    if (acc) exp_q.push_back(ref_decode(s));
  endtask

  task automatic push_hold(input stim_t s, input logic rdy);
    logic acc = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) cycle(s, rdy, 1'b0, acc);
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_hold: op not accepted within 8 cycles, expected acceptance");
    end
  endtask

  logic  acc;
  stim_t st;
  logic [5:0] legal_fn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};

  initial begin
    bus.valid_i = 1'b0; bus.alu_op_i = '0; bus.funct_i = '0; bus.shamt_i = '0;
    bus.alu_src_i = 1'b0; bus.rs_data_i = '0; bus.rt_data_i = '0; bus.imm_i = '0;
    bus.ready_i = 1'b0;

    // Reset state
    #12;
    check("rst_valid_o",   W'(bus.valid_o), '0);
    check("rst_src1_o",    bus.src1_o, '0);
    check("rst_src2_o",    bus.src2_o, '0);
    check("rst_control_o", W'(bus.alu_control_o), '0);
    check("rst_illegal_o", W'(bus.illegal_o), '0);
    @(posedge clk); #3 rst_n = 1'b1;

    // Single add, then idle
    cycle(mk(3'b010, 6'h20, 5'd0, 1'b0, 32'd5, 32'd7, 32'd0), 1'b1, 1'b0, acc);
    check("add_accepted", W'(acc), W'(1));
    cycle(idle(), 1'b1, 1'b0, acc);
    cycle(idle(), 1'b1, 1'b0, acc);

    // sll uses shamt as src1
    cycle(mk(3'b010, 6'h00, 5'd3, 1'b0, 32'hDEAD_BEEF, 32'h1, 32'd0), 1'b1, 1'b0, acc);
    cycle(idle(), 1'b1, 1'b0, acc);

    // Backpressure: third op held until space opens
    cycle(mk(3'b000, 6'h3F, 5'd1, 1'b1, 32'd10, 32'd11, 32'd4), 1'b0, 1'b0, acc);
    cycle(mk(3'b001, 6'h00, 5'd2, 1'b0, 32'd20, 32'd21, 32'd9), 1'b0, 1'b0, acc);
    st = mk(3'b100, 6'h11, 5'd0, 1'b1, 32'd30, 32'd31, 32'hFF);
    cycle(st, 1'b0, 1'b0, acc);
    check("bp_third_held", W'(acc), W'(0));
    cycle(st, 1'b0, 1'b0, acc);
    check("bp_third_held2", W'(acc), W'(0));
    push_hold(st, 1'b1);
    repeat (3) cycle(idle(), 1'b1, 1'b0, acc);

    // Accept+issue at count=1 for four cycles
    cycle(mk(3'b011, 6'd0, 5'd0, 1'b1, 32'd1, 32'd2, 32'd3), 1'b0, 1'b0, acc);
    for (int i = 0; i < 4; i++) begin
      cycle(mk(3'b010, legal_fn[i], 5'(i), 1'b0, 32'(100 + i), 32'(200 + i), 32'd0), 1'b1, 1'b0,
            acc);
      check("stream_accept", W'(acc), W'(1));
    end
    repeat (2) cycle(idle(), 1'b1, 1'b0, acc);

    // Flush at count=2 with a simultaneous valid op
    cycle(mk(3'b000, 6'd0, 5'd0, 1'b0, 32'd1, 32'd2, 32'd0), 1'b0, 1'b0, acc);
    cycle(mk(3'b101, 6'd0, 5'd0, 1'b1, 32'd3, 32'd4, 32'd5), 1'b0, 1'b0, acc);
    cycle(mk(3'b001, 6'd0, 5'd0, 1'b0, 32'h55, 32'h66, 32'd0), 1'b0, 1'b1, acc);
    check("flush_drop", W'(acc), W'(0));
    repeat (2) cycle(idle(), 1'b1, 1'b0, acc);

    // Illegal ALUOp, then async reset during a stall
    cycle(mk(3'b111, 6'h20, 5'd0, 1'b0, 32'd8, 32'd9, 32'd0), 1'b1, 1'b0, acc);
    cycle(idle(), 1'b1, 1'b0, acc);
    cycle(mk(3'b010, 6'h22, 5'd0, 1'b0, 32'd40, 32'd41, 32'd0), 1'b0, 1'b0, acc);
    cycle(mk(3'b010, 6'h3F, 5'd0, 1'b0, 32'd42, 32'd43, 32'd0), 1'b0, 1'b0, acc);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid_o", W'(bus.valid_o), '0);
    check("async_rst_illegal_o", W'(bus.illegal_o), '0);
    check("async_rst_src1_o", bus.src1_o, '0);
    exp_q.delete();
    bus.valid_i = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      st.v   = ($urandom_range(0, 9) < 7);
      st.op  = 3'($urandom_range(0, 7));
      st.fn  = ($urandom_range(0, 9) < 7) ? legal_fn[$urandom_range(0, 5)] : 6'($urandom);
      st.sh  = 5'($urandom);
      st.src = 1'($urandom);
      st.rs  = $urandom;
      st.rt  = $urandom;
      st.imm = $urandom;
      cycle(st, ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3), acc);
    end

    // Drain with a bounded cycle budget
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) cycle(idle(), 1'b1, 1'b0, acc);
    cycle(idle(), 1'b1, 1'b0, acc);
    check("drain_empty", W'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX-side producer of the ALU operand/control interface: decodes ALUOp/funct into the 4-bit ALU control code and selects src1/src2.
- Holds decoded operations in a 2-entry buffer and presents them to the ALU with a valid/ready handshake.
- Sits between the decode stage (upstream) and the EX-stage ALU (downstream).
- Lets decode run one op ahead of an EX stall without a combinational ready path.

Parameters:
WIDTH, 32, datapath width of operands
ALUCONTROL_WIDTH, 4, width of ALU control code
DEPTH, 2, buffer entries (fixed at 2; other values unsupported)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
flush_i  input  1  synchronous flush; drops all buffered ops
valid_i  input  1  upstream op valid
ready_o  output  1  buffer can accept an op
alu_op_i  input  3  main-control ALUOp
funct_i  input  6  R-type funct field
shamt_i  input  5  shift amount
alu_src_i  input  1  1 = src2 from imm_i, 0 = src2 from rt_data_i
rs_data_i  input  WIDTH  rs register value
rt_data_i  input  WIDTH  rt register value
imm_i  input  WIDTH  immediate, already extended upstream
valid_o  output  1  op presented to ALU
ready_i  input  1  EX stage accepts op
src1_o  output  WIDTH  ALU operand 1
src2_o  output  WIDTH  ALU operand 2
alu_control_o  output  ALUCONTROL_WIDTH  ALU control code
illegal_o  output  1  presented op had an undecodable ALUOp/funct

Behaviour:
- Reset (rst_i low, asynchronous):
  - count=0, valid_o=0, src1_o/src2_o/alu_control_o/illegal_o=0.
  - ready_o=1 from the first cycle after release.
- Decode is combinational on inputs, written into the buffer on accept:
  - ALUOp 000 -> 0010 (add: lw/sw/addi); 001 -> 0110 (sub: beq).
  - ALUOp 010, by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 000000 -> 1000 (sll).
  - ALUOp 011 -> 0111 (slti); 100 -> 0001 (ori); 101 -> 0000 (andi).
  - Anything else -> 1111 with illegal bit set.
- Operands:
  - src1 = rs_data_i, except sll: src1 = shamt_i zero-extended to WIDTH.
  - src2 = alu_src_i ? imm_i : rt_data_i.
  - No arithmetic is performed here.
- Handshake:
  - accept = valid_i & ready_o; issue = valid_o & ready_i.
  - ready_o = (count < 2), registered only from count; no combinational path from ready_i.
  - valid_o = (count != 0). Outputs always show the head entry.
  - Outputs are held stable while valid_o=1 and ready_i=0.
- Count update:
  - accept only: +1; issue only: −1; both: unchanged, head advances, new op enqueued behind.
  - count=2: ready_o=0, so no accept is possible.
  - count=1 with accept+issue: the new op becomes head on the next cycle.
- Latency: op accepted at edge N (buffer empty) has valid_o=1 and correct outputs in cycle after edge N, i.e. 1 cycle.
- Storage: entries are a 2-slot circular buffer with 1-bit read/write pointers that wrap 1->0.
- flush_i:
  - At next edge: count=0, pointers=0, valid_o=0.
  - Has priority over a simultaneous accept (input op dropped) and over issue.
  - Output data values after flush are don't-care but valid_o must be 0.
- Reset mid-operation: all buffered ops are lost immediately; no op is issued.
- illegal_o is the stored illegal bit of the head entry. An illegal op is still issued normally; the ALU produces 0 for code 1111.

Test Plan:
- Reset then single add: alu_op=010, funct=100000, rs=5, rt=7, alu_src=0, ready_i=1 -> next cycle valid_o=1, src1=5, src2=7, control=0010; following cycle valid_o=0.
- sll decode: alu_op=010, funct=000000, shamt=3, rt=0x1 -> src1=3, src2=0x1, control=1000.
- Backpressure: ready_i=0, push 3 ops (addi imm=4, beq, ori imm=0xFF) -> ready_o drops after 2nd accept, 3rd held upstream; head stays addi (0010, src2=4). Raise ready_i -> issued in order 0010, 0110, 0001.
- Simultaneous accept+issue at count=1 for 4 consecutive cycles -> one op issued per cycle, count stays 1, order preserved.
- Flush with count=2 and valid_i=1 the same cycle -> next cycle valid_o=0, ready_o=1, dropped op never appears.
- Illegal ALUOp=111 -> control=1111, illegal_o=1; async reset asserted mid-stall -> valid_o=0 immediately without a clock edge.
